// File: rtl/spy_playback_sequencer_pkg.sv
// Shared definitions for the spy playback sequencer: playback mode encodings
// and the sequencer state enumeration.
package spy_pkg;

  localparam logic [1:0] NO_PLAYBACK    = 2'd0;
  localparam logic [1:0] PLAYBACK_ONCE  = 2'd1;
  localparam logic [1:0] PLAYBACK_LOOP  = 2'd2;
  localparam logic [1:0] PLAYBACK_WRITE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_WRITE = 3'd5
  } state_e;

endpackage

// File: rtl/spy_playback_sequencer_valid_pipe.sv
// Valid-bit shift register that tracks spy reads in flight. The last stage
// lines up with the cycle the memory presents the read data.
module spy_valid_pipe #(
  parameter int LATENCY = 1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic flush_i,
  input  logic valid_i,
  output logic valid_o,
  output logic empty_o
);

  logic [LATENCY-1:0] pipe_q;
  logic [LATENCY:0]   chain_s;

  assign chain_s = {pipe_q, valid_i};
  assign valid_o = chain_s[LATENCY];
  assign empty_o = ~|pipe_q;

  // Advance every stage by one; reset or flush discards all reads in flight.
  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      pipe_q <= {LATENCY{1'b0}};
    end else begin
      pipe_q <= chain_s[LATENCY-1:0];
    end
  end

endmodule

// File: rtl/spy_playback_sequencer.sv
// Spy playback sequencer: replays an address window of spy memory into the
// flow-control FIFO once, a counted number of passes, or forever, and passes
// external RAM writes through in WRITE mode.
module spy_playback_sequencer
  import spy_pkg::*;
#(
  parameter int DATAWIDTH    = 64,
  parameter int MEMWIDTH     = 6,
  parameter int READ_LATENCY = 1,
  parameter int LOOPW        = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           playback,
  input  logic [MEMWIDTH-1:0]  start_addr,
  input  logic [MEMWIDTH-1:0]  stop_addr,
  input  logic [LOOPW-1:0]     loop_count,
  input  logic                 full,
  input  logic [DATAWIDTH:0]   spy_read_data,
  input  logic                 ram_write_enable_ext,
  input  logic [DATAWIDTH:0]   ram_write_data_ext,
  output logic                 spy_read_enable,
  output logic [MEMWIDTH-1:0]  spy_read_addr,
  output logic                 playback_enable,
  output logic [DATAWIDTH:0]   playback_data,
  output logic                 ram_write_enable,
  output logic [DATAWIDTH:0]   ram_write_data,
  output logic                 busy,
  output logic                 done,
  output logic [LOOPW-1:0]     passes_done
);

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [MEMWIDTH-1:0] addr_q, addr_d;
  logic [MEMWIDTH-1:0] start_q, start_d;
  logic [MEMWIDTH-1:0] stop_q, stop_d;
  logic [LOOPW-1:0]    loops_q, loops_d;
  logic [LOOPW-1:0]    passes_q, passes_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ram_we_q, ram_we_d;
  logic [DATAWIDTH:0]  ram_wd_q, ram_wd_d;

  logic                abort_s;
  logic                rd_en_s;
  logic                last_pass_s;
  logic [LOOPW-1:0]    passes_inc_s;
  logic                pipe_valid_s;
  logic                pipe_empty_s;

  // Any mode change outside IDLE abandons the current activity; the abort
  // also suppresses a read that would otherwise issue in the same cycle.
  assign abort_s = (state_q != ST_IDLE) && (playback != mode_q);
  assign rd_en_s = (state_q == ST_RUN) && !full && !abort_s && !reset;

  assign passes_inc_s = (passes_q == {LOOPW{1'b1}}) ? passes_q
                                                     : passes_q + LOOPW'(1'b1);
  // loop_count of zero never matches, so infinite loops never finish.
  assign last_pass_s  = (mode_q == PLAYBACK_ONCE) ||
                        ((loops_q != {LOOPW{1'b0}}) && (passes_inc_s == loops_q));

  assign busy_d   = (state_d == ST_RUN) || (state_d == ST_HOLD) || (state_d == ST_DRAIN);
  assign ram_we_d = (playback == PLAYBACK_WRITE) ? ram_write_enable_ext : 1'b0;
  assign ram_wd_d = (playback == PLAYBACK_WRITE) ? ram_write_data_ext
                                                 : {(DATAWIDTH+1){1'b0}};

  spy_valid_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_valid_pipe (
    .clock_i (clock),
    .reset_i (reset),
    .flush_i (abort_s),
    .valid_i (rd_en_s),
    .valid_o (pipe_valid_s),
    .empty_o (pipe_empty_s)
  );

  // Next-state logic: launch/abort dispatch, window walk, hold on full, drain.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    start_d  = start_q;
    stop_d   = stop_q;
    loops_d  = loops_q;
    passes_d = passes_q;
    done_d   = done_q;
    if (abort_s || (state_q == ST_IDLE)) begin
      mode_d   = playback;
      passes_d = {LOOPW{1'b0}};
      done_d   = 1'b0;
      case (playback)
        PLAYBACK_ONCE, PLAYBACK_LOOP: begin
          state_d = ST_RUN;
          start_d = start_addr;
          stop_d  = stop_addr;
          loops_d = loop_count;
          addr_d  = start_addr;
        end
        PLAYBACK_WRITE: begin
          state_d = ST_WRITE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      case (state_q)
        ST_RUN: begin
          if (full) begin
            state_d = ST_HOLD;
          end else if (addr_q == stop_q) begin
            passes_d = passes_inc_s;
            if (last_pass_s) begin
              state_d = ST_DRAIN;
            end else begin
              addr_d = start_q;
            end
          end else begin
            addr_d = addr_q + MEMWIDTH'(1'b1);
          end
        end
        ST_HOLD: begin
          if (!full) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          if (pipe_empty_s) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        ST_WRITE: begin
          state_d = ST_WRITE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= NO_PLAYBACK;
      addr_q   <= start_addr;
      start_q  <= {MEMWIDTH{1'b0}};
      stop_q   <= {MEMWIDTH{1'b0}};
      loops_q  <= {LOOPW{1'b0}};
      passes_q <= {LOOPW{1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ram_we_q <= 1'b0;
      ram_wd_q <= {(DATAWIDTH+1){1'b0}};
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      loops_q  <= loops_d;
      passes_q <= passes_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ram_we_q <= ram_we_d;
      ram_wd_q <= ram_wd_d;
    end
  end

  assign spy_read_enable  = rd_en_s;
  assign spy_read_addr    = addr_q;
  assign playback_enable  = pipe_valid_s;
  assign playback_data    = pipe_valid_s ? spy_read_data : {(DATAWIDTH+1){1'b0}};
  assign ram_write_enable = ram_we_q;
  assign ram_write_data   = ram_wd_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign passes_done      = passes_q;

endmodule

// File: tb/tb_spy_playback_sequencer.sv
// Directed bench for spy_playback_sequencer with a 2-cycle spy memory model.
module tb_spy_playback_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  playback = 2'd0;
  logic [5:0]  start_addr = 6'd0;
  logic [5:0]  stop_addr = 6'd0;
  logic [7:0]  loop_count = 8'd0;
  logic        full = 1'b0;
  logic [16:0] spy_read_data;
  logic        ram_write_enable_ext = 1'b0;
  logic [16:0] ram_write_data_ext = 17'd0;
  logic        spy_read_enable;
  logic [5:0]  spy_read_addr;
  logic        playback_enable;
  logic [16:0] playback_data;
  logic        ram_write_enable;
  logic [16:0] ram_write_data;
  logic        busy;
  logic        done;
  logic [7:0]  passes_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_while_full = 0;
  logic [5:0]  rd_log[$];
  int          rd_cyc[$];
  logic [16:0] wr_log[$];
  logic [16:0] rdp0, rdp1;

  spy_playback_sequencer #(
    .DATAWIDTH(16), .MEMWIDTH(6), .READ_LATENCY(2), .LOOPW(8)
  ) dut (
    .clock(clock), .reset(reset), .playback(playback),
    .start_addr(start_addr), .stop_addr(stop_addr), .loop_count(loop_count),
    .full(full), .spy_read_data(spy_read_data),
    .ram_write_enable_ext(ram_write_enable_ext), .ram_write_data_ext(ram_write_data_ext),
    .spy_read_enable(spy_read_enable), .spy_read_addr(spy_read_addr),
    .playback_enable(playback_enable), .playback_data(playback_data),
    .ram_write_enable(ram_write_enable), .ram_write_data(ram_write_data),
    .busy(busy), .done(done), .passes_done(passes_done)
  );

  always #5 clock = ~clock;

  function automatic logic [16:0] mem_val(input logic [5:0] a);
    return {a[0], 8'h5A, 2'b10, a};
  endfunction

  // Spy memory model: data appears two cycles after the read strobe; idle
  // cycles return a non-zero filler word.
  always @(posedge clock) begin
    rdp0 <= spy_read_enable ? mem_val(spy_read_addr) : 17'h15A5A;
    rdp1 <= rdp0;
  end
  assign spy_read_data = rdp1;

  // Log reads and FIFO writes; reset clears the logs.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      rd_log.delete();
      rd_cyc.delete();
      wr_log.delete();
      rd_while_full <= 0;
    end else begin
      if (spy_read_enable) begin
        rd_log.push_back(spy_read_addr);
        rd_cyc.push_back(cyc);
        if (full) rd_while_full <= rd_while_full + 1;
      end
      if (playback_enable) wr_log.push_back(playback_data);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    playback = 2'd0;
    full = 1'b0;
    ram_write_enable_ext = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done) break;
      @(negedge clock);
    end
    #1;
    check("done_timeout", done, 1'b1);
  endtask

  typedef struct {
    logic [1:0]  pb;
    logic        fl;
    logic        rd;
    logic [5:0]  addr;
    logic        pe;
    logic [16:0] pd;
    logic        bsy;
    logic        dn;
    logic [7:0]  pas;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] pb, input logic fl, input logic rd,
                              input logic [5:0] addr, input logic pe, input logic [16:0] pd,
                              input logic bsy, input logic dn, input logic [7:0] pas);
    vec_t v;
    v.pb = pb; v.fl = fl; v.rd = rd; v.addr = addr; v.pe = pe;
    v.pd = pd; v.bsy = bsy; v.dn = dn; v.pas = pas;
    return v;
  endfunction

  vec_t vt[10];

  initial begin
    // ONCE over 2..5, cycle by cycle from the first cycle after reset.
    vt[0] = mk(2'd1, 1'b0, 1'b0, 6'd2, 1'b0, 17'd0,         1'b0, 1'b0, 8'd0);
    vt[1] = mk(2'd1, 1'b0, 1'b1, 6'd2, 1'b0, 17'd0,         1'b1, 1'b0, 8'd0);
    vt[2] = mk(2'd1, 1'b0, 1'b1, 6'd3, 1'b0, 17'd0,         1'b1, 1'b0, 8'd0);
    vt[3] = mk(2'd1, 1'b0, 1'b1, 6'd4, 1'b1, mem_val(6'd2), 1'b1, 1'b0, 8'd0);
    vt[4] = mk(2'd1, 1'b0, 1'b1, 6'd5, 1'b1, mem_val(6'd3), 1'b1, 1'b0, 8'd0);
    vt[5] = mk(2'd1, 1'b0, 1'b0, 6'd5, 1'b1, mem_val(6'd4), 1'b1, 1'b0, 8'd1);
    vt[6] = mk(2'd1, 1'b0, 1'b0, 6'd5, 1'b1, mem_val(6'd5), 1'b1, 1'b0, 8'd1);
    vt[7] = mk(2'd1, 1'b0, 1'b0, 6'd5, 1'b0, 17'd0,         1'b1, 1'b0, 8'd1);
    vt[8] = mk(2'd1, 1'b0, 1'b0, 6'd5, 1'b0, 17'd0,         1'b0, 1'b1, 8'd1);
    vt[9] = mk(2'd1, 1'b0, 1'b0, 6'd5, 1'b0, 17'd0,         1'b0, 1'b1, 8'd1);

    start_addr = 6'd2; stop_addr = 6'd5; loop_count = 8'd0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clock);
      playback = vt[i].pb;
      full = vt[i].fl;
      #1;
      check($sformatf("once_rd_en[%0d]", i), spy_read_enable, vt[i].rd);
      check($sformatf("once_addr[%0d]", i), spy_read_addr, vt[i].addr);
      check($sformatf("once_pb_en[%0d]", i), playback_enable, vt[i].pe);
      check($sformatf("once_pb_data[%0d]", i), playback_data, vt[i].pd);
      check($sformatf("once_busy[%0d]", i), busy, vt[i].bsy);
      check($sformatf("once_done[%0d]", i), done, vt[i].dn);
      check($sformatf("once_passes[%0d]", i), passes_done, vt[i].pas);
    end

    // LOOP x3 over a window that wraps through the top of memory.
    start_addr = 6'd60; stop_addr = 6'd1; loop_count = 8'd3;
    do_reset();
    playback = 2'd2;
    wait_done(100);
    check("loop_passes", passes_done, 8'd3);
    check("loop_busy", busy, 1'b0);
    check("loop_rd_count", rd_log.size(), 18);
    check("loop_wr_count", wr_log.size(), 18);
    if (rd_cyc.size() == 18) check("loop_no_bubble", rd_cyc[17] - rd_cyc[0], 17);
    else check("loop_rd_cyc_count", rd_cyc.size(), 18);
    for (int i = 0; i < 18 && i < rd_log.size() && i < wr_log.size(); i++) begin
      logic [5:0] a;
      a = 6'd60 + 6'(i % 6);
      check($sformatf("loop_rd[%0d]", i), rd_log[i], a);
      check($sformatf("loop_wr[%0d]", i), wr_log[i], mem_val(a));
    end

    // ONCE over 0..15 with full high for cycles 5..9.
    start_addr = 6'd0; stop_addr = 6'd15; loop_count = 8'd0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clock);
      playback = 2'd1;
      full = (c >= 5 && c <= 9);
    end
    wait_done(100);
    check("full_rd_while_full", rd_while_full, 0);
    check("full_wr_count", wr_log.size(), 16);
    check("full_rd_count", rd_log.size(), 16);
    for (int i = 0; i < 16 && i < wr_log.size() && i < rd_log.size(); i++) begin
      check($sformatf("full_rd[%0d]", i), rd_log[i], 6'(i));
      check($sformatf("full_wr[%0d]", i), wr_log[i], mem_val(6'(i)));
    end
    check("full_passes", passes_done, 8'd1);

    // Infinite LOOP aborted to NO_PLAYBACK mid-pass.
    start_addr = 6'd10; stop_addr = 6'd13; loop_count = 8'd0;
    do_reset();
    playback = 2'd2;
    repeat (6) @(negedge clock);
    #1;
    check("abort_pre_passes", passes_done, 8'd1);
    @(negedge clock);
    playback = 2'd0;
    #1;
    check("abort_rd_suppressed", spy_read_enable, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      check($sformatf("abort_pb_en[%0d]", i), playback_enable, 1'b0);
    end
    check("abort_done", done, 1'b0);
    check("abort_passes", passes_done, 8'd0);
    check("abort_busy", busy, 1'b0);

    // Reset asserted during an infinite LOOP with reads in flight.
    start_addr = 6'd0; stop_addr = 6'd2; loop_count = 8'd0;
    do_reset();
    playback = 2'd2;
    repeat (4) @(negedge clock);
    #1;
    check("rst_pre_pb_en", playback_enable, 1'b1);
    check("rst_pre_passes", passes_done, 8'd1);
    reset = 1'b1;
    playback = 2'd0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_pb_en", playback_enable, 1'b0);
    check("rst_pb_data", playback_data, 17'd0);
    check("rst_rd_en", spy_read_enable, 1'b0);
    check("rst_addr", spy_read_addr, 6'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_passes", passes_done, 8'd0);
    check("rst_ram_we", ram_write_enable, 1'b0);
    check("rst_ram_wd", ram_write_data, 17'd0);
    repeat (4) @(negedge clock);
    check("rst_no_writes", wr_log.size(), 0);

    // WRITE pass-through; external strobes are ignored in other modes.
    do_reset();
    ram_write_enable_ext = 1'b1;
    ram_write_data_ext = 17'h3;
    @(negedge clock);
    #1;
    check("nowr_ram_we", ram_write_enable, 1'b0);
    check("nowr_ram_wd", ram_write_data, 17'd0);
    playback = 2'd3;
    ram_write_data_ext = 17'hA;
    @(negedge clock);
    #1;
    check("wr_ram_we0", ram_write_enable, 1'b1);
    check("wr_ram_wd0", ram_write_data, 17'hA);
    check("wr_rd_en0", spy_read_enable, 1'b0);
    ram_write_data_ext = 17'hB;
    @(negedge clock);
    #1;
    check("wr_ram_we1", ram_write_enable, 1'b1);
    check("wr_ram_wd1", ram_write_data, 17'hB);
    check("wr_rd_en1", spy_read_enable, 1'b0);
    ram_write_data_ext = 17'hC;
    @(negedge clock);
    #1;
    check("wr_ram_we2", ram_write_enable, 1'b1);
    check("wr_ram_wd2", ram_write_data, 17'hC);
    check("wr_busy", busy, 1'b0);
    ram_write_enable_ext = 1'b0;
    ram_write_data_ext = 17'h5;
    @(negedge clock);
    #1;
    check("wr_ram_we_off", ram_write_enable, 1'b0);
    check("wr_ram_wd_follow", ram_write_data, 17'h5);
    check("wr_pb_en", playback_enable, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
